reg_wb_arbiter: RTL and testbench

- Write-port controller for the 32x32 CPU register file, which has one write port (Rw/RegWr/busW, written on posedge Clk).
- Shares that port between the in-order pipeline writeback and a long-latency result source (mul/div/load return).
- Keeps a busy scoreboard of destinations owed by long ops so decode can stall on RAW/WAW hazards.
- Prevents starvation of the long source by holding the pipeline.

---
 rtl/reg_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-port controller for the 32x32 CPU register file.
//
// The single register-file write port (Rw/RegWr/busW) is shared between the
// in-order pipeline writeback and a long-latency result source (mul/div/load
// return). The long source wins only when the pipeline is idle, or once it
// has been refused MAX_WAIT cycles in a row, at which point pipe_hold stalls
// the pipeline. A busy scoreboard records destinations still owed by long
// ops, so decode can stall on RAW/WAW hazards.
//
// Ports:
//   Clk, Rst                       clock, synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data   pipeline writeback request (no handshake)
//   long_valid/long_rd/long_data   long-latency result, long_ready = accept
//   iss_valid/iss_rd, iss_full     long-op issue and outstanding-limit flag
//   chk_ra/chk_rb/chk_rd, hz_stall decode hazard check against busy vector
//   pipe_hold                      pipeline must not write back this cycle
//   Rw/RegWr/busW                  registered register-file write port
//   busy                           scoreboard, bit i = register i owed
module reg_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned MAX_OUT  = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        long_valid,
    input  logic [4:0]  long_rd,
    input  logic [31:0] long_data,
    output logic        long_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_full,
    input  logic [4:0]  chk_ra,
    input  logic [4:0]  chk_rb,
    input  logic [4:0]  chk_rd,
    output logic        hz_stall,
    output logic        pipe_hold,
    output logic [4:0]  Rw,
    output logic        RegWr,
    output logic [31:0] busW,
    output logic [31:0] busy
);

    localparam int unsigned      WaitW   = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
    localparam logic [4:0]       OutMax  = 5'(MAX_OUT);

    logic [WaitW-1:0] wait_q, wait_d;
    logic [4:0]       out_q, out_d;
    logic [31:0]      busy_q, busy_d;
    logic [4:0]       rw_q, rw_d;
    logic [31:0]      bus_w_q, bus_w_d;
    logic             reg_wr_q, reg_wr_d;
    // Set when the write currently on the port came from a long grant; its
    // destination is rw_q, so the scoreboard clear needs no separate copy.
    logic             wb_long_q, wb_long_d;

    logic long_grant, pipe_win, iss_acc;

    assign pipe_hold  = (wait_q >= WaitMax);
    assign long_ready = long_valid & (pipe_hold | ~pipe_valid);
    assign long_grant = long_valid & long_ready;
    assign pipe_win   = pipe_valid & ~pipe_hold;

    assign iss_full = (out_q == OutMax);
    assign iss_acc  = iss_valid & ~iss_full;

    assign hz_stall = busy_q[chk_ra] | busy_q[chk_rb] | busy_q[chk_rd];

    assign Rw    = rw_q;
    assign RegWr = reg_wr_q;
    assign busW  = bus_w_q;
    assign busy  = busy_q;

    // Write port: winner of this cycle appears on the port next cycle.
    always_comb begin
        rw_d      = rw_q;
        bus_w_d   = bus_w_q;
        reg_wr_d  = 1'b0;
        wb_long_d = 1'b0;
        if (long_grant) begin
            rw_d      = long_rd;
            bus_w_d   = long_data;
            reg_wr_d  = (long_rd != 5'd0);
            wb_long_d = 1'b1;
        end else if (pipe_win) begin
            rw_d     = pipe_rd;
            bus_w_d  = pipe_data;
            reg_wr_d = (pipe_rd != 5'd0);
        end
    end

    // Starvation counter: counts consecutive refusals of a valid long result.
    always_comb begin
        wait_d = '0;
        if (long_valid && !long_ready) begin
            wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
        end
    end

    // Scoreboard: clear lands on the register-file write edge; a set on the
    // same edge is applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_long_q) begin
            busy_d[rw_q] = 1'b0;
        end
        if (iss_acc && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    always_comb begin
        unique case ({iss_acc, wb_long_q})
            2'b10:   out_d = out_q + 5'd1;
            2'b01:   out_d = (out_q == 5'd0) ? out_q : out_q - 5'd1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wait_q    <= '0;
            out_q     <= '0;
            busy_q    <= '0;
            rw_q      <= '0;
            bus_w_q   <= '0;
            reg_wr_q  <= 1'b0;
            wb_long_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            bus_w_q   <= bus_w_d;
            reg_wr_q  <= reg_wr_d;
            wb_long_q <= wb_long_d;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_reg_wb_arbiter;

    localparam int MaxWait = 4;
    localparam int MaxOut  = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        pipe_valid, long_valid, iss_valid;
    logic [4:0]  pipe_rd, long_rd, iss_rd, chk_ra, chk_rb, chk_rd;
    logic [31:0] pipe_data, long_data;
    logic        long_ready, iss_full, hz_stall, pipe_hold, RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW, busy;

    always #5 Clk = ~Clk;

    reg_wb_arbiter #(.MAX_WAIT(MaxWait), .MAX_OUT(MaxOut)) dut (
        .Clk(Clk), .Rst(Rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .long_valid(long_valid), .long_rd(long_rd), .long_data(long_data),
        .long_ready(long_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_full(iss_full),
        .chk_ra(chk_ra), .chk_rb(chk_rb), .chk_rd(chk_rd), .hz_stall(hz_stall),
        .pipe_hold(pipe_hold), .Rw(Rw), .RegWr(RegWr), .busW(busW), .busy(busy)
    );

    // Register file as seen by the CPU, written from the DUT write port.
    logic [31:0] rf [32];
    always @(posedge Clk) if (RegWr === 1'b1) rf[Rw] <= busW;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counters as ints, owed completions as a queue.
    int          m_wait, m_out;
    logic [31:0] m_busy;
    logic        m_wr;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;
    logic [31:0] mrf [32];
    logic [31:0] m_written;
    int          pend[$];

    task automatic model_reset();
        m_wait = 0; m_out = 0; m_busy = '0;
        m_wr = 1'b0; m_rw = '0; m_busw = '0;
        pend.delete();
    endtask

    // One clock: check combinational outputs, clock, check registered ones.
    task automatic cyc();
        bit hold, rdy, acc, done;
        int r;
        #2;
        hold = (m_wait >= MaxWait);
        rdy  = long_valid && (hold || !pipe_valid);
        acc  = iss_valid && (m_out != MaxOut);
        if (!Rst) begin
            chk("pipe_hold", {31'b0, pipe_hold}, {31'b0, hold});
            chk("long_ready", {31'b0, long_ready}, {31'b0, rdy});
            chk("iss_full", {31'b0, iss_full}, {31'b0, (m_out == MaxOut)});
            chk("hz_stall", {31'b0, hz_stall},
                {31'b0, m_busy[chk_ra] | m_busy[chk_rb] | m_busy[chk_rd]});
        end
        @(posedge Clk);
        if (m_wr) begin
            mrf[m_rw] = m_busw;
            m_written[m_rw] = 1'b1;
        end
        if (Rst) begin
            model_reset();
        end else begin
            done = (pend.size() > 0);
            if (done) begin
                r = pend.pop_front();
                m_busy[r] = 1'b0;
            end
            if (acc && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            m_out = m_out + int'(acc) - int'(done);
            if (m_out < 0) m_out = 0;
            if (rdy) begin
                pend.push_back(int'(long_rd));
                m_wr = (long_rd != 0); m_rw = long_rd; m_busw = long_data;
            end else if (pipe_valid && !hold) begin
                m_wr = (pipe_rd != 0); m_rw = pipe_rd; m_busw = pipe_data;
            end else begin
                m_wr = 1'b0;
            end
            m_wait = (long_valid && !rdy) ? ((m_wait + 1 > MaxWait) ? MaxWait : m_wait + 1) : 0;
        end
        #1;
        chk("RegWr", {31'b0, RegWr}, {31'b0, m_wr});
        chk("Rw", {27'b0, Rw}, {27'b0, m_rw});
        chk("busW", busW, m_busw);
        chk("busy", busy, m_busy);
    endtask

    task automatic idle();
        pipe_valid = 0; long_valid = 0; iss_valid = 0;
        pipe_rd = 0; long_rd = 0; iss_rd = 0; pipe_data = 0; long_data = 0;
        chk_ra = 0; chk_rb = 0; chk_rd = 0;
    endtask

    typedef struct {
        logic        pv;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_wr;
        logic [4:0]  exp_rw;
        logic [31:0] exp_busw;
    } vec_t;

    vec_t tbl [5];

    initial begin
        m_written = '0;
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
        tbl[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h00001234};
        tbl[2] = '{1'b0, 5'd9,  32'h0000AAAA, 1'b0, 5'd0,  32'h00001234};
        tbl[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
        tbl[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};

        idle();
        Rst = 1;
        @(posedge Clk); @(posedge Clk); #1;
        model_reset();
        chk("rst_RegWr", {31'b0, RegWr}, 32'd0);
        chk("rst_Rw", {27'b0, Rw}, 32'd0);
        chk("rst_busW", busW, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_hold", {31'b0, pipe_hold}, 32'd0);
        chk("rst_full", {31'b0, iss_full}, 32'd0);
        Rst = 0;

        // Pipeline writeback table.
        for (int i = 0; i < 5; i++) begin
            pipe_valid = tbl[i].pv; pipe_rd = tbl[i].rd; pipe_data = tbl[i].data;
            cyc();
            chk("tbl_RegWr", {31'b0, RegWr}, {31'b0, tbl[i].exp_wr});
            chk("tbl_Rw", {27'b0, Rw}, {27'b0, tbl[i].exp_rw});
            chk("tbl_busW", busW, tbl[i].exp_busw);
            if (i == 1) chk("rf5", rf[5], 32'hDEADBEEF);
        end
        idle();
        cyc();

        // Long result to x0: accepted, never written.
        long_valid = 1; long_rd = 0; long_data = 32'hCAFE0000;
        #1 chk("x0_ready", {31'b0, long_ready}, 32'd1);
        cyc();
        chk("x0_RegWr", {31'b0, RegWr}, 32'd0);
        idle();
        cyc();

        // Issue rd 7, then its long result; busy clears on the write edge.
        iss_valid = 1; iss_rd = 7;
        cyc();
        idle();
        long_valid = 1; long_rd = 7; long_data = 32'h55; chk_ra = 7;
        #1;
        chk("b7_set", {31'b0, busy[7]}, 32'd1);
        chk("b7_hz", {31'b0, hz_stall}, 32'd1);
        chk("b7_ready", {31'b0, long_ready}, 32'd1);
        cyc();
        long_valid = 0;
        chk("b7_wr", {31'b0, RegWr}, 32'd1);
        chk("b7_rw", {27'b0, Rw}, 32'd7);
        chk("b7_still", {31'b0, busy[7]}, 32'd1);
        cyc();
        #1;
        chk("b7_clr", {31'b0, busy[7]}, 32'd0);
        chk("b7_hz0", {31'b0, hz_stall}, 32'd0);
        chk("rf7", rf[7], 32'h55);
        idle();

        // Starvation: pipe_hold after MaxWait refusals.
        pipe_valid = 1; pipe_rd = 3; pipe_data = 32'h33;
        long_valid = 1; long_rd = 4; long_data = 32'h44;
        for (int i = 0; i < MaxWait; i++) begin
            #1 chk("starve_ready0", {31'b0, long_ready}, 32'd0);
            cyc();
        end
        #1;
        chk("starve_hold", {31'b0, pipe_hold}, 32'd1);
        chk("starve_ready", {31'b0, long_ready}, 32'd1);
        cyc();
        #1;
        chk("starve_release", {31'b0, pipe_hold}, 32'd0);
        idle();
        cyc(); cyc();

        // Fill the outstanding limit, then overflow and completion+issue.
        for (int i = 1; i <= 4; i++) begin
            iss_valid = 1; iss_rd = 5'(i);
            cyc();
        end
        #1 chk("full", {31'b0, iss_full}, 32'd1);
        iss_rd = 9;
        cyc();
        chk("ovf_b9", {31'b0, busy[9]}, 32'd0);
        iss_valid = 0; long_valid = 1; long_rd = 1;
        cyc();
        long_valid = 0;
        cyc();
        #1 chk("after_done", {31'b0, iss_full}, 32'd0);
        long_valid = 1; long_rd = 2;
        cyc();
        long_valid = 0; iss_valid = 1; iss_rd = 10;
        cyc();
        iss_valid = 0;
        #1;
        chk("same_edge_full", {31'b0, iss_full}, 32'd0);
        chk("same_edge_b10", {31'b0, busy[10]}, 32'd1);
        chk("same_edge_b2", {31'b0, busy[2]}, 32'd0);
        iss_valid = 1; iss_rd = 11;
        cyc();
        iss_valid = 0;
        #1 chk("refull", {31'b0, iss_full}, 32'd1);

        // Reset with busy bits and a pending long result.
        Rst = 1; long_valid = 1; long_rd = 3; pipe_valid = 1; pipe_rd = 6;
        cyc();
        Rst = 0;
        chk("rst2_busy", busy, 32'd0);
        chk("rst2_RegWr", {31'b0, RegWr}, 32'd0);
        #1;
        chk("rst2_hold", {31'b0, pipe_hold}, 32'd0);
        chk("rst2_full", {31'b0, iss_full}, 32'd0);
        chk("rst2_ready_pv1", {31'b0, long_ready}, 32'd0);
        pipe_valid = 0;
        #1 chk("rst2_ready_pv0", {31'b0, long_ready}, 32'd1);
        idle();
        cyc();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            Rst        = ($urandom_range(0, 199) == 0);
            pipe_valid = ($urandom_range(0, 99) < 60);
            pipe_rd    = 5'($urandom);
            pipe_data  = $urandom;
            long_valid = ($urandom_range(0, 99) < 40);
            long_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            long_data  = $urandom;
            iss_valid  = ($urandom_range(0, 99) < 30);
            iss_rd     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            chk_ra     = 5'($urandom);
            chk_rb     = 5'($urandom);
            chk_rd     = 5'($urandom);
            cyc();
        end
        Rst = 0;
        idle();
        cyc(); cyc();
        for (int i = 1; i < 32; i++) begin
            if (m_written[i]) chk("rf_final", rf[i], mrf[i]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
